// File: rtl/cpu_sequencer_if.sv
// Data-memory request/ready handshake between the CPU sequencer
// and the data memory.
interface cpu_sequencer_if;
  logic       mem_req;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic       mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    output mem_ready
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for a small 16-bit-instruction CPU:
// fetch/decode/execute FSM, PC, IR, data-memory handshake, retire count.
module cpu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        zero_flag,
  input  logic [7:0]  rs_data,
  output logic [1:0]  rs,
  output logic [1:0]  rt,
  output logic [1:0]  nd,
  output logic [7:0]  imm,
  output logic [2:0]  alucs,
  output logic        selscrB,
  output logic        regdes,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        flagwrite,
  cpu_sequencer_if.master mem,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADC  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [7:0]  maddr;
  logic [3:0]  op;
  logic [3:0]  dop;
  logic        is_alu;
  logic        dec_mem;
  logic        done;
  logic        take;
  logic        launch;

  assign op      = ir[15:12];
  assign dop     = imem_rdata[15:12];
  assign dec_mem = (dop == OP_LD) || (dop == OP_ST);
  assign is_alu  = (op <= OP_ADC);

  assign imem_addr    = pc;
  assign rs           = ir[11:10];
  assign rt           = ir[9:8];
  assign imm          = ir[7:0];
  assign nd           = regdes ? ir[7:6] : ir[9:8];
  assign halted       = (state == S_HALT);
  assign mem.mem_addr = maddr;

  // An instruction completes when it leaves EXEC, WB, or MEM as a store.
  assign done = (state == S_EXEC)
              | (state == S_WB)
              | ((state == S_MEM) && mem.mem_ready && (op == OP_ST));

  assign take = (state == S_EXEC)
              && ((op == OP_JMP) || ((op == OP_BEQZ) && zero_flag));

  assign launch = ((state == S_IDLE) || (state == S_HALT)) && start;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_HALT:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = dec_mem ? S_MEM : S_EXEC;
      S_EXEC:   state_nxt = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_MEM: begin
        if (mem.mem_ready)
          state_nxt = (op == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB:     state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    alucs       = 3'b000;
    selscrB     = 1'b0;
    regdes      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    flagwrite   = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    unique case (state)
      S_EXEC: begin
        if (is_alu) begin
          regwrite  = 1'b1;
          flagwrite = 1'b1;
          regdes    = 1'b1;
        end
        if (op == OP_ADDI) begin
          regwrite  = 1'b1;
          flagwrite = 1'b1;
          selscrB   = 1'b1;
        end
        unique case (1'b1)
          (op == OP_SUB): alucs = 3'b001;
          (op == OP_AND): alucs = 3'b010;
          (op == OP_OR):  alucs = 3'b011;
          (op == OP_ADC): alucs = 3'b100;
          default:        alucs = 3'b000;
        endcase
      end
      S_MEM: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = (op == OP_ST);
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= 8'h00;
      ir      <= 16'h0000;
      maddr   <= 8'h00;
      retired <= 16'h0000;
    end else begin
      state <= state_nxt;
      // The ROM word is valid during DECODE; the address uses it directly.
      if (state == S_DECODE) begin
        ir <= imem_rdata;
        if (dec_mem)
          maddr <= rs_data + imem_rdata[7:0];
      end
      if (launch)
        pc <= 8'h00;
      else if (done && !((state == S_EXEC) && (op == OP_HALT)))
        pc <= take ? ir[7:0] : pc + 8'd1;
      if (done && (retired != 16'hFFFF))
        retired <= retired + 16'd1;
    end
  end

endmodule
